// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - limb-serial multi-precision adder controller driving an external 16-bit datapath
//
// Ports:
//   clk, rstn                       clock, synchronous active-low reset
//   in_valid/in_ready               request handshake; op_a, op_b, cin_in sampled on acceptance
//   out_valid/out_ready             result handshake; sum_out, carry_out held until consumed
//   busy                            high whenever the controller is not idle
//   dp_d_a, dp_d_b, dp_en_a/b       operand limb and load enables for the datapath input registers
//   dp_en_result, dp_cin            result register enable and carry-in for the datapath adder
//   dp_result, dp_cout              stored datapath sum limb and its combinational carry-out
module add_seq_ctrl #(
   parameter int N_LIMBS = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [16*N_LIMBS-1:0]  op_a,
   input  logic [16*N_LIMBS-1:0]  op_b,
   input  logic                   cin_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [16*N_LIMBS-1:0]  sum_out,
   output logic                   carry_out,
   output logic                   busy,
   output logic [15:0]            dp_d_a,
   output logic [15:0]            dp_d_b,
   output logic                   dp_en_a,
   output logic                   dp_en_b,
   output logic                   dp_en_result,
   output logic                   dp_cin,
   input  logic [15:0]            dp_result,
   input  logic                   dp_cout
);

   localparam int W     = 16 * N_LIMBS;
   localparam int IDX_W = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LIMBS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ADD,
      S_CAPT,
      S_DONE
   } state_t;

   state_t            r_state;
   logic [IDX_W-1:0]  r_idx;
   logic              r_carry;
   logic [W-1:0]      r_op_a;
   logic [W-1:0]      r_op_b;
   logic [W-1:0]      r_sum;

   logic              r_in_ready;
   logic              r_out_valid;
   logic [W-1:0]      r_sum_out;
   logic              r_carry_out;
   logic              r_busy;
   logic [15:0]       r_dp_d_a;
   logic [15:0]       r_dp_d_b;
   logic              r_dp_en_a;
   logic              r_dp_en_b;
   logic              r_dp_en_result;
   logic              r_dp_cin;

   logic [IDX_W-1:0]  w_idx_nxt;
   logic [W-1:0]      w_sum_nxt;

   assign w_idx_nxt = r_idx + IDX_W'(1);

   // Sum buffer with the limb being captured this cycle already merged in,
   // so the final limb reaches sum_out on the same edge that enters DONE.
   always_comb begin
      w_sum_nxt = r_sum;
      w_sum_nxt[r_idx*16 +: 16] = dp_result;
   end

   // All outputs are registered: each one is assigned on the edge that
   // enters the state in which it must be visible.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state        <= S_IDLE;
         r_idx          <= '0;
         r_carry        <= 1'b0;
         r_op_a         <= '0;
         r_op_b         <= '0;
         r_sum          <= '0;
         r_in_ready     <= 1'b1;
         r_out_valid    <= 1'b0;
         r_sum_out      <= '0;
         r_carry_out    <= 1'b0;
         r_busy         <= 1'b0;
         r_dp_d_a       <= '0;
         r_dp_d_b       <= '0;
         r_dp_en_a      <= 1'b0;
         r_dp_en_b      <= 1'b0;
         r_dp_en_result <= 1'b0;
         r_dp_cin       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_op_a     <= op_a;
                  r_op_b     <= op_b;
                  r_carry    <= cin_in;
                  r_idx      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_dp_d_a   <= op_a[15:0];
                  r_dp_d_b   <= op_b[15:0];
                  r_dp_en_a  <= 1'b1;
                  r_dp_en_b  <= 1'b1;
                  r_state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_dp_d_a       <= '0;
               r_dp_d_b       <= '0;
               r_dp_en_a      <= 1'b0;
               r_dp_en_b      <= 1'b0;
               r_dp_en_result <= 1'b1;
               r_dp_cin       <= r_carry;
               r_state        <= S_ADD;
            end
            S_ADD: begin
               // dp_cout is the carry of the limb add presented this cycle.
               r_carry        <= dp_cout;
               r_dp_en_result <= 1'b0;
               r_dp_cin       <= 1'b0;
               r_state        <= S_CAPT;
            end
            S_CAPT: begin
               r_sum <= w_sum_nxt;
               if (r_idx == LAST_IDX) begin
                  r_sum_out   <= w_sum_nxt;
                  r_carry_out <= r_carry;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_idx     <= w_idx_nxt;
                  r_dp_d_a  <= r_op_a[w_idx_nxt*16 +: 16];
                  r_dp_d_b  <= r_op_b[w_idx_nxt*16 +: 16];
                  r_dp_en_a <= 1'b1;
                  r_dp_en_b <= 1'b1;
                  r_state   <= S_LOAD;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign sum_out      = r_sum_out;
   assign carry_out    = r_carry_out;
   assign busy         = r_busy;
   assign dp_d_a       = r_dp_d_a;
   assign dp_d_b       = r_dp_d_b;
   assign dp_en_a      = r_dp_en_a;
   assign dp_en_b      = r_dp_en_b;
   assign dp_en_result = r_dp_en_result;
   assign dp_cin       = r_dp_cin;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb/tb_add_seq_ctrl.sv - scoreboard bench for add_seq_ctrl with a behavioural 16-bit datapath
module tb_add_seq_ctrl;

   localparam int N = 4;
   localparam int W = 16 * N;

   logic          clk = 1'b0;
   logic          rstn;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          cin_in;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum_out;
   logic          carry_out;
   logic          busy;
   logic [15:0]   dp_d_a;
   logic [15:0]   dp_d_b;
   logic          dp_en_a;
   logic          dp_en_b;
   logic          dp_en_result;
   logic          dp_cin;
   logic [15:0]   dp_result;
   logic          dp_cout;

   always #5 clk = ~clk;

   add_seq_ctrl #(.N_LIMBS(N)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .op_a         (op_a),
      .op_b         (op_b),
      .cin_in       (cin_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .sum_out      (sum_out),
      .carry_out    (carry_out),
      .busy         (busy),
      .dp_d_a       (dp_d_a),
      .dp_d_b       (dp_d_b),
      .dp_en_a      (dp_en_a),
      .dp_en_b      (dp_en_b),
      .dp_en_result (dp_en_result),
      .dp_cin       (dp_cin),
      .dp_result    (dp_result),
      .dp_cout      (dp_cout)
   );

   // External datapath: two operand registers, a combinational 16-bit adder
   // and a result register.
   logic [15:0] dpa = '0;
   logic [15:0] dpb = '0;
   logic [15:0] dpres = '0;
   logic [16:0] dp_sum;
   assign dp_sum    = {1'b0, dpa} + {1'b0, dpb} + {16'd0, dp_cin};
   assign dp_cout   = dp_sum[16];
   assign dp_result = dpres;

   always @(posedge clk) begin
      if (dp_en_a)      dpa   <= dp_d_a;
      if (dp_en_b)      dpb   <= dp_d_b;
      if (dp_en_result) dpres <= dp_sum[15:0];
   end

   typedef struct {
      logic [W-1:0] sum;
      logic         c;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   int   ready_mode = 2;   // 0 random, 1 hold low, 2 always high

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
      checks++;
      if (act === exp_v) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
   endtask

   task automatic fail_now(input string name);
      checks++;
      $display("FAIL %s: got timeout/unexpected event expected normal progress (cycle %0d)", name, cyc);
   endtask

   // Reference: the whole request is one unsigned addition.
   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
   endfunction

   // Acceptance monitor: pushes the expected result for every accepted request.
   always @(posedge clk) begin
      exp_t       e;
      logic [W:0] full;
      cyc = cyc + 1;
      if (!rstn) begin
         sb.delete();
      end else if (in_valid && in_ready) begin
         full  = ref_add(op_a, op_b, cin_in);
         e.sum = full[W-1:0];
         e.c   = full[W];
         e.acc = cyc;
         sb.push_back(e);
      end
   end

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = ($urandom_range(0, 3) != 0);
         1:       out_ready = 1'b0;
         default: out_ready = 1'b1;
      endcase
   end

   // Output monitor: pops on the first cycle of each result, then checks that
   // the result holds until it is consumed.
   bit           seen = 0;
   logic [W-1:0] cap_sum;
   logic         cap_c;

   always @(negedge clk) begin
      exp_t m;
      logic ok;
      if (rstn) begin
         ok = (dp_en_a == dp_en_b) && (dp_en_a || (dp_d_a == 16'd0 && dp_d_b == 16'd0)) &&
              (dp_en_result || !dp_cin) && !(dp_en_a && dp_en_result) &&
              (in_ready == !busy) && (!out_valid || busy);
         chk("dp_protocol", W'(ok), W'(1));
      end
      if (!rstn) begin
         seen = 0;
      end else if (out_valid) begin
         if (!seen) begin
            if (sb.size() == 0) begin
               fail_now("unexpected_out_valid");
            end else begin
               m = sb.pop_front();
               chk("sum_out", sum_out, m.sum);
               chk("carry_out", W'(carry_out), W'(m.c));
               // The LOAD cycle right after acceptance counts as cycle 1.
               chk("latency", W'(cyc - m.acc + 1), W'(3 * N + 1));
            end
            cap_sum = sum_out;
            cap_c   = carry_out;
            seen    = 1;
         end else begin
            chk("hold_sum", sum_out, cap_sum);
            chk("hold_carry", W'(carry_out), W'(cap_c));
         end
         if (out_ready) seen = 0;
      end else begin
         seen = 0;
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, W'(in_ready), W'(1));
      chk({tag, "_out_valid"}, W'(out_valid), W'(0));
      chk({tag, "_busy"}, W'(busy), W'(0));
      chk({tag, "_sum_out"}, sum_out, '0);
      chk({tag, "_carry_out"}, W'(carry_out), W'(0));
      chk({tag, "_dp"}, W'({dp_d_a, dp_d_b, dp_en_a, dp_en_b, dp_en_result, dp_cin}), '0);
   endtask

   task automatic req(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      cin_in   = c;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) fail_now("req_timeout");
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input bit junk);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         if (junk && busy && !out_valid) begin
            in_valid = 1'($urandom_range(0, 1));
            op_a     = {$urandom, $urandom};
            op_b     = {$urandom, $urandom};
            cin_in   = 1'($urandom_range(0, 1));
         end else begin
            in_valid = 1'b0;
         end
         n++;
      end while ((busy || sb.size() != 0) && n < 300);
      if (busy || sb.size() != 0) fail_now("wait_idle_timeout");
      in_valid = 1'b0;
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      logic [W:0]   full;
      int           n;
      int           adds;

      rstn     = 1'b0;
      in_valid = 1'b0;
      op_a     = '0;
      op_b     = '0;
      cin_in   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("in_reset");
      rstn = 1'b1;
      @(negedge clk);
      chk_reset_vals("after_reset");

      // Directed carry-propagation cases.
      ready_mode = 2;
      req(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
      wait_idle(0);
      req(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
      wait_idle(0);
      req(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0);
      wait_idle(0);

      // Backpressure: result held for several cycles, then released.
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = 1'b1;
      full = ref_add(a, b, c);
      ready_mode = 1;
      req(a, b, c);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) fail_now("done_timeout");
      repeat (5) @(negedge clk);
      chk("bp_out_valid", W'(out_valid), W'(1));
      ready_mode = 2;
      n = 0;
      while (!out_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("bp_idle_busy", W'(busy), W'(0));
      chk("bp_idle_in_ready", W'(in_ready), W'(1));
      chk("bp_idle_out_valid", W'(out_valid), W'(0));
      repeat (3) @(negedge clk);
      chk("idle_retain_sum", sum_out, full[W-1:0]);
      chk("idle_retain_carry", W'(carry_out), W'(full[W]));

      // Requests pulsed while busy must be ignored.
      req({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      wait_idle(1);

      // Reset during the second ADD aborts the operation.
      req({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      adds = 0;
      n = 0;
      while (adds < 2 && n < 50) begin
         @(negedge clk);
         if (dp_en_result) adds++;
         n++;
      end
      if (adds < 2) fail_now("second_add_timeout");
      rstn = 1'b0;
      @(negedge clk);
      chk_reset_vals("abort");
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort_no_out_valid", W'(out_valid), W'(0));
      req(64'h1234_5678_9ABC_DEF0, 64'hEDCB_A987_6543_2110, 1'b0);
      wait_idle(0);

      // Randomized traffic with backpressure, idle gaps and busy-time noise.
      ready_mode = 0;
      for (int t = 0; t < 25; t++) begin
         case ($urandom_range(0, 3))
            0:       a = '1;
            1:       a = {48'd0, 16'hFFFF};
            default: a = {$urandom, $urandom};
         endcase
         b = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) b = '0;
         req(a, b, 1'($urandom_range(0, 1)));
         wait_idle(1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      ready_mode = 2;
      wait_idle(0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
